// File: rtl/ex_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: 32 radix-2 steps plus a sign-fix cycle.
// Shift-add multiply, restoring divide, MTHI/MTLO writes and an optional flush abort.
module ex_muldiv #(
    parameter bit FLUSH_ABORT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_in,
    input  logic [31:0] rt_in,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned REM_W = XLEN + 1;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              is_div, is_div_n;
    logic              neg_lo, neg_lo_n;
    logic              neg_hi, neg_hi_n;
    logic              div_zero, div_zero_n;
    logic [XLEN-1:0]   a_raw, a_raw_n;
    logic [XLEN-1:0]   opb, opb_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [REM_W-1:0]  rem, rem_n;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic              busy_n, done_n;

    logic              signed_op;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [REM_W-1:0]  mul_sum;
    logic [ACC_W-1:0]  mul_step;
    logic [REM_W-1:0]  div_shift, div_diff;
    logic              div_ge;
    logic [ACC_W-1:0]  prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Operand magnitudes for the signed ops; unsigned ops pass through raw
    always_comb begin
        signed_op = ~op[0];
        a_abs = (signed_op && rs_in[31]) ? (~rs_in + 32'd1) : rs_in;
        b_abs = (signed_op && rt_in[31]) ? (~rt_in + 32'd1) : rt_in;
    end

    // One radix-2 step of each algorithm; acc[31:0] holds multiplier or quotient bits
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, opb};
        mul_step  = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};
        div_shift = {rem[XLEN-1:0], acc[31]};
        div_diff  = div_shift - {1'b0, opb};
        div_ge    = rem[XLEN] | (div_shift >= {1'b0, opb});
    end

    // Sign correction applied in FIX
    always_comb begin
        prod_fix = neg_lo ? (~acc + 64'd1) : acc;
        quo_fix  = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_hi ? (~rem[XLEN-1:0] + 32'd1) : rem[XLEN-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_n    = state;
        count_n    = count;
        is_div_n   = is_div;
        neg_lo_n   = neg_lo;
        neg_hi_n   = neg_hi;
        div_zero_n = div_zero;
        a_raw_n    = a_raw;
        opb_n      = opb;
        acc_n      = acc;
        rem_n      = rem;
        hi_n       = hi_out;
        lo_n       = lo_out;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (hi_we) hi_n = wdata;
                if (lo_we) lo_n = wdata;
                if (start && !flush) begin
                    state_n    = BUSY;
                    count_n    = '0;
                    is_div_n   = op[1];
                    a_raw_n    = rs_in;
                    div_zero_n = (rt_in == 32'd0);
                    neg_lo_n   = signed_op && (rs_in[31] ^ rt_in[31]);
                    neg_hi_n   = signed_op && rs_in[31];
                    rem_n      = '0;
                    if (op[1]) begin
                        opb_n = b_abs;
                        acc_n = {32'd0, a_abs};
                    end else begin
                        opb_n = a_abs;
                        acc_n = {32'd0, b_abs};
                    end
                end
            end
            BUSY: begin
                if (FLUSH_ABORT && flush) begin
                    state_n = IDLE;
                end else begin
                    if (is_div) begin
                        rem_n = div_ge ? div_diff : div_shift;
                        acc_n = {acc[63:32], acc[30:0], div_ge};
                    end else begin
                        acc_n = mul_step;
                    end
                    count_n = count + 5'd1;
                    if (count == 5'(XLEN - 1)) state_n = FIX;
                end
            end
            FIX: begin
                state_n = IDLE;
                if (!(FLUSH_ABORT && flush)) begin
                    done_n = 1'b1;
                    if (!is_div) begin
                        hi_n = prod_fix[63:32];
                        lo_n = prod_fix[31:0];
                    end else if (div_zero) begin
                        hi_n = a_raw;
                        lo_n = 32'hFFFF_FFFF;
                    end else begin
                        hi_n = rem_fix;
                        lo_n = quo_fix;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opb      <= '0;
            acc      <= '0;
            rem      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            is_div   <= is_div_n;
            neg_lo   <= neg_lo_n;
            neg_hi   <= neg_hi_n;
            div_zero <= div_zero_n;
            a_raw    <= a_raw_n;
            opb      <= opb_n;
            acc      <= acc_n;
            rem      <= rem_n;
            hi_out   <= hi_n;
            lo_out   <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule
